// File: rtl/counter_sched_if.sv
// Request/grant/read bundle between event sources and the shared counter bank.
interface counter_sched_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 64,
  parameter int unsigned SW = 2
);
  logic          En;
  logic [N-1:0]  Req;
  logic [N-1:0]  Clr;
  logic [SW-1:0] RdSel;
  logic [W-1:0]  RdData;
  logic [N-1:0]  Gnt;
  logic [N-1:0]  Ovf;
  logic          Busy;

  modport master (
    output En, Req, Clr, RdSel,
    input  RdData, Gnt, Ovf, Busy
  );

  modport slave (
    input  En, Req, Clr, RdSel,
    output RdData, Gnt, Ovf, Busy
  );
endinterface

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one increment datapath among N requesters,
// with saturating per-channel pending counters and a registered read port.
module counter_sched #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 64,
  parameter int unsigned PW = 4,
  parameter int unsigned SW = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  counter_sched_if.slave bus
);

  localparam logic [PW-1:0] PendMax = {PW{1'b1}};

  logic [W-1:0]  cnt_q  [N];
  logic [W-1:0]  cnt_d  [N];
  logic [PW-1:0] pend_q [N];
  logic [PW-1:0] pend_d [N];
  logic [N-1:0]  ovf_q, ovf_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  elig;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  rd_q, rd_d;
  logic          busy;

  logic          hi_found, lo_found, win_valid;
  logic [SW-1:0] hi_idx, lo_idx, win;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = (pend_q[i] != '0) && !bus.Clr[i];
    end
  end

  // Two-pass priority: lowest eligible index above ptr first, else lowest at or below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (SW'(i) > ptr_q) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = SW'(i);
      end
      if (elig[i] && (SW'(i) <= ptr_q) && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
      end
    end
    win_valid = bus.En && (hi_found || lo_found);
    win       = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < N; i++) begin
      gnt_d[i] = win_valid && (win == SW'(i));
    end
    ptr_d = win_valid ? win : ptr_q;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      pend_d[i] = pend_q[i];
      ovf_d[i]  = ovf_q[i];
      if (bus.Clr[i]) begin
        cnt_d[i]  = '0;
        pend_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end else begin
        if (gnt_d[i]) begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
        if (bus.Req[i] && !gnt_d[i]) begin
          // A full counter drops the event and remembers it.
          if (pend_q[i] == PendMax) begin
            ovf_d[i] = 1'b1;
          end else begin
            pend_d[i] = pend_q[i] + PW'(1);
          end
        end else if (!bus.Req[i] && gnt_d[i]) begin
          pend_d[i] = pend_q[i] - PW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_d = '0;
    busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.RdSel == SW'(i)) begin
        rd_d = cnt_q[i];
      end
      if (pend_q[i] != '0) begin
        busy = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      ovf_q <= '0;
      gnt_q <= '0;
      ptr_q <= SW'(N - 1);
      rd_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pend_q[i] <= pend_d[i];
      end
      ovf_q <= ovf_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      rd_q  <= rd_d;
    end
  end

  assign bus.Gnt    = gnt_q;
  assign bus.Ovf    = ovf_q;
  assign bus.RdData = rd_q;
  assign bus.Busy   = busy;

endmodule
